t07_mem_responder: RTL and testbench

T07_MEM_RESPONDER -- requirements
Module: t07_mem_responder

---
 rtl/t07_mem_pkg.sv | 28 ++
 rtl/t07_sram_model.sv | 22 ++
 rtl/t07_mem_responder.sv | 104 ++++++++++
 tb/tb_t07_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/t07_mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Holds the request codes, the controller states and the bad-address read value.
package t07_mem_pkg;

  typedef enum logic [1:0] {
    RWI_IDLE  = 2'b00,
    RWI_WRITE = 2'b01,
    RWI_READ  = 2'b10,
    RWI_FETCH = 2'b11
  } rwi_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/t07_sram_model.sv
// Single-port synchronous SRAM: one read/write port, registered read data.
// Contents are deliberately not reset.
module t07_sram_model #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Range guard only matters for non-power-of-two depths.
  always_ff @(posedge clk) begin
    if (we && (int'(addr) < DEPTH)) mem[addr] <= wdata;
    rdata <= (int'(addr) < DEPTH) ? mem[addr] : '0;
  end

endmodule

// File: rtl/t07_mem_responder.sv
// Memory responder with per-op wait states: captures a request in IDLE,
// counts down in WAIT, performs the access as busy falls, then idles one cycle in DONE.
module t07_mem_responder
  import t07_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rwi_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = width_for((RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT);
  localparam logic [CW-1:0] RD_CNT = CW'(RD_WAIT);
  localparam logic [CW-1:0] WR_CNT = CW'(WR_WAIT);

  state_e        state, state_d;
  rwi_e          op_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          bad_q;
  logic [CW-1:0] cnt;

  logic          capture, finish, bad_in, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;

  assign bad_in = (addr_i[1:0] != 2'b00) || (addr_i[31:2] >= 30'(DEPTH));

  always_comb begin
    state_d = state;
    capture = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: if (rwi_i != RWI_IDLE) begin
        capture = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (cnt == '0) begin
        finish  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // The SRAM is addressed from addr_i in IDLE so its registered read data is
  // already valid at the completion edge, even with zero wait cycles.
  assign sram_addr = (state == ST_IDLE) ? addr_i[AW+1:2] : idx_q;
  assign sram_we   = finish && (op_q == RWI_WRITE) && !bad_q;

  t07_sram_model #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= RWI_IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
      cnt     <= '0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      err_o <= finish && bad_q;
      if (capture) begin
        op_q    <= rwi_e'(rwi_i);
        idx_q   <= addr_i[AW+1:2];
        wdata_q <= wdata_i;
        bad_q   <= bad_in;
        cnt     <= (rwi_i == RWI_WRITE) ? WR_CNT : RD_CNT;
        busy_o  <= 1'b1;
      end else if (state == ST_WAIT) begin
        if (finish) begin
          busy_o <= 1'b0;
          if (op_q != RWI_WRITE) rdata_o <= bad_q ? ERR_DATA : sram_rdata;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_t07_mem_responder.sv
// Bench for t07_mem_responder: directed table, reset abort, random traffic
// against a word-array model, and a zero-wait instance.
module tb_t07_mem_responder;

  localparam int DEPTH = 256;
  localparam int RD_W  = 2;
  localparam int WR_W  = 1;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_FE = 2'b11;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]  rwi = 2'b00, rwi0 = 2'b00;
  logic [31:0] addr = '0, addr0 = '0, wdata = '0, wdata0 = '0;
  logic [31:0] rdata, rdata0;
  logic        busy, busy0, err, err0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  t07_mem_responder #(.DEPTH(DEPTH), .RD_WAIT(RD_W), .WR_WAIT(WR_W)) dut (
    .clk(clk), .rst(rst), .rwi_i(rwi), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .busy_o(busy), .err_o(err)
  );

  t07_mem_responder #(.DEPTH(DEPTH), .RD_WAIT(0), .WR_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .rwi_i(rwi0), .addr_i(addr0), .wdata_i(wdata0),
    .rdata_o(rdata0), .busy_o(busy0), .err_o(err0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    if (sel == 0) begin rwi = op; addr = a; wdata = wd; end
    else begin rwi0 = op; addr0 = a; wdata0 = wd; end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  // Reference behaviour: bad addresses never write and read back BAD.
  function automatic void model_apply(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] wd);
    if (is_bad(a)) begin
      if (op != OP_WR) last_rd = BAD;
    end else if (op == OP_WR) begin
      ref_mem[int'(a[31:2])] = wd;
    end else begin
      last_rd = ref_mem[int'(a[31:2])];
    end
  endfunction

  // Issues one request, scrambles inputs while busy and during DONE, and
  // checks busy length, completion outputs and that DONE ignores rwi.
  task automatic do_req(input int sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err);
    int n, exp_busy;
    logic fell, b, e;
    logic [31:0] rd;
    exp_busy = (sel != 0) ? 1 : ((op == OP_WR) ? WR_W + 1 : RD_W + 1);
    @(negedge clk);
    drive(sel, op, a, wd);
    n = 0;
    fell = 1'b0;
    b = 1'b0; e = 1'b0; rd = '0;
    while (!fell && n < 20) begin
      @(posedge clk); #1;
      b  = (sel == 0) ? busy  : busy0;
      e  = (sel == 0) ? err   : err0;
      rd = (sel == 0) ? rdata : rdata0;
      if (b) begin
        n++;
        check("err_while_busy", 32'(e), 32'd0);
        drive(sel, 2'($urandom_range(0, 3)), $urandom, $urandom);
      end else begin
        fell = 1'b1;
      end
    end
    if (!fell) begin
      n_vec++; n_err++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, expected %0d", n, exp_busy);
    end
    check("busy_cycles", 32'(n), 32'(exp_busy));
    check("err_at_fall", 32'(e), 32'(exp_err));
    check("rdata_at_fall", rd, exp_rd);
    drive(sel, 2'($urandom_range(1, 3)), $urandom, $urandom);
    @(posedge clk); #1;
    check("done_not_accepted", 32'((sel == 0) ? busy : busy0), 32'd0);
    check("err_one_cycle", 32'((sel == 0) ? err : err0), 32'd0);
    drive(sel, 2'b00, '0, '0);
  endtask

  task automatic model_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
    model_apply(op, a, wd);
    do_req(0, op, a, wd, last_rd, is_bad(a));
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    int r;

    tbl[0]  = '{OP_WR, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl[1]  = '{OP_WR, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1'b0};
    tbl[2]  = '{OP_RD, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
    tbl[3]  = '{OP_FE, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
    tbl[4]  = '{OP_RD, 32'h0000_0013, 32'h0,         BAD,           1'b1};
    tbl[5]  = '{OP_RD, 32'h0000_0400, 32'h0,         BAD,           1'b1};
    tbl[6]  = '{OP_WR, 32'h0000_0400, 32'hDEAD_BEEF, BAD,           1'b1};
    tbl[7]  = '{OP_RD, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[8]  = '{OP_WR, 32'h0000_0020, 32'hAAAA_AAAA, 32'hCAFE_F00D, 1'b0};
    tbl[9]  = '{OP_WR, 32'h0000_0011, 32'h5555_5555, 32'hCAFE_F00D, 1'b1};
    tbl[10] = '{OP_RD, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};

    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      model_apply(tbl[i].op, tbl[i].addr, tbl[i].wdata);
      do_req(0, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
    end

    // Reset in the middle of a write's wait: write must be dropped.
    @(negedge clk);
    drive(0, OP_WR, 32'h0000_0020, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    drive(0, 2'b00, '0, '0);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    model_req(OP_RD, 32'h0000_0020, '0);
    check("abort_kept_old", rdata, 32'hAAAA_AAAA);

    for (int i = 0; i < 16; i++) model_req(OP_WR, 32'(i) << 2, $urandom);

    for (int k = 0; k < 150; k++) begin
      op = 2'($urandom_range(1, 3));
      r  = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else             a = 32'h0000_0400 + (32'($urandom_range(0, 4095)) << 2);
      model_req(op, a, $urandom);
    end

    do_req(1, OP_WR, 32'h0000_0008, 32'h5A5A_1234, 32'h0,         1'b0);
    do_req(1, OP_RD, 32'h0000_0008, 32'h0,         32'h5A5A_1234, 1'b0);
    do_req(1, OP_FE, 32'h0000_0008, 32'h0,         32'h5A5A_1234, 1'b0);
    do_req(1, OP_RD, 32'h0000_0007, 32'h0,         BAD,           1'b1);
    do_req(1, OP_WR, 32'h0000_0404, 32'h1111_1111, BAD,           1'b1);
    do_req(1, OP_FE, 32'h0000_0008, 32'h0,         32'h5A5A_1234, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
